ac_sequencer: RTL and testbench

AC_SEQUENCER -- requirements
Module: ac_sequencer

---
 rtl/ac_sequencer.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ac_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_sequencer.sv
// PDP-8 style instruction sequencer: fetch, defer, auto-index, execute and write-back control.
// Latency: controls are combinational from the state register; one state per clock, memory states wait on mem_done.
// Backpressure: memory strobes stay asserted until mem_done; reset abandons any outstanding cycle.

package ac_sequencer_pkg;
  typedef enum logic [2:0] {AC_NC, AC_MICRO, AC_AND, AC_TAD, AC_CLEAR} ac_ctrl_e;
  typedef enum logic [1:0] {LK_NC, LK_MICRO, LK_TAD}                   lk_ctrl_e;
  typedef enum logic [1:0] {PC_NC, PC_P1, PC_P2, PC_JMP}               pc_ctrl_e;
  typedef enum logic       {IR_NC, IR_LD}                              ir_ctrl_e;
  typedef enum logic [2:0] {EA_NC, EA_PGE, EA_SMP, EA_IND, EA_INC}     ea_ctrl_e;
  typedef enum logic [1:0] {MB_NC, MB_RD, MB_INC}                      mb_ctrl_e;
  typedef enum logic [1:0] {WD_NC, WD_MB, WD_AC, WD_PCP1}              wd_ctrl_e;
  typedef enum logic [1:0] {AD_NC, AD_PC, AD_EA}                       ad_ctrl_e;
endpackage

module ac_sequencer
  import ac_sequencer_pkg::*;
#(
  parameter logic [11:0] HLT_CODE = 12'o7402
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
  input  logic [11:0] ir,
  input  logic        ea_in_auto,
  input  logic        mb_is_zero,
  input  logic        skip,
  input  logic        mem_done,
  output ac_ctrl_e    AC_ctrl,
  output lk_ctrl_e    LK_ctrl,
  output pc_ctrl_e    PC_ctrl,
  output ir_ctrl_e    IR_ctrl,
  output ea_ctrl_e    EA_ctrl,
  output mb_ctrl_e    MB_ctrl,
  output wd_ctrl_e    WD_ctrl,
  output ad_ctrl_e    AD_ctrl,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    IDLE, F_AD, F_RD, DEC, I_AD, I_RD, I_CHK, A_WD,
    E_AD, E_RD, EXEC, WR_WD, WR, JMS_P1, HALT
  } state_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  state_e     r_state;
  state_e     w_next;
  logic       r_auto;   // set while the pending write is an auto-index pointer update
  logic [2:0] w_opcode;

  assign w_opcode = ir[11:9];
  assign halted   = (r_state == HALT);

  // State register and write-context flag; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_auto  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == A_WD) begin
        r_auto <= 1'b1;
      end else if ((r_state == WR) && mem_done) begin
        r_auto <= 1'b0;
      end
    end
  end

  // Next-state and control decode; anything not driven by a state stays at its NC value.
  always_comb begin
    w_next     = r_state;
    AC_ctrl    = AC_NC;
    LK_ctrl    = LK_NC;
    PC_ctrl    = PC_NC;
    IR_ctrl    = IR_NC;
    EA_ctrl    = EA_NC;
    MB_ctrl    = MB_NC;
    WD_ctrl    = WD_NC;
    AD_ctrl    = AD_NC;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    instr_done = 1'b0;

    case (r_state)
      IDLE: begin
        if (run) w_next = F_AD;
      end

      F_AD: begin
        // Stop request is honoured at the boundary, before the next fetch starts.
        AD_ctrl = AD_PC;
        w_next  = halt_req ? HALT : F_RD;
      end

      F_RD: begin
        // PC is left alone here; it advances only when the instruction retires.
        mem_rd = 1'b1;
        if (mem_done) begin
          IR_ctrl = IR_LD;
          w_next  = DEC;
        end
      end

      DEC: begin
        case (w_opcode)
          OP_IOT: begin
            PC_ctrl    = PC_P1;
            instr_done = 1'b1;
            w_next     = F_AD;
          end
          OP_OPR: begin
            if (ir == HLT_CODE) begin
              PC_ctrl = PC_P1;
              w_next  = HALT;
            end else begin
              // skip is evaluated on the AC value before this microinstruction updates it.
              AC_ctrl    = AC_MICRO;
              LK_ctrl    = LK_MICRO;
              PC_ctrl    = skip ? PC_P2 : PC_P1;
              instr_done = 1'b1;
              w_next     = F_AD;
            end
          end
          default: begin
            // Memory-reference instruction: form EA on current page or page zero.
            EA_ctrl = ir[7] ? EA_PGE : EA_SMP;
            w_next  = ir[8] ? I_AD : E_AD;
          end
        endcase
      end

      I_AD: begin
        AD_ctrl = AD_EA;
        w_next  = I_RD;
      end

      I_RD: begin
        mem_rd = 1'b1;
        if (mem_done) begin
          MB_ctrl = MB_RD;
          w_next  = I_CHK;
        end
      end

      I_CHK: begin
        if (ea_in_auto) begin
          // Auto-index: bump the pointer and use the bumped value as the operand address.
          MB_ctrl = MB_INC;
          EA_ctrl = EA_INC;
          w_next  = A_WD;
        end else begin
          EA_ctrl = EA_IND;
          w_next  = E_AD;
        end
      end

      A_WD: begin
        // AD is not reloaded, so the write-back lands on the pointer word itself.
        WD_ctrl = WD_MB;
        w_next  = WR;
      end

      E_AD: begin
        AD_ctrl = AD_EA;
        case (w_opcode)
          OP_JMP: begin
            PC_ctrl    = PC_JMP;
            instr_done = 1'b1;
            w_next     = F_AD;
          end
          OP_DCA: begin
            WD_ctrl = WD_AC;
            w_next  = WR;
          end
          OP_JMS: begin
            WD_ctrl = WD_PCP1;
            w_next  = WR;
          end
          default: begin
            w_next = E_RD;
          end
        endcase
      end

      E_RD: begin
        mem_rd = 1'b1;
        if (mem_done) begin
          MB_ctrl = MB_RD;
          w_next  = EXEC;
        end
      end

      EXEC: begin
        case (w_opcode)
          OP_AND: begin
            AC_ctrl    = AC_AND;
            PC_ctrl    = PC_P1;
            instr_done = 1'b1;
            w_next     = F_AD;
          end
          OP_TAD: begin
            AC_ctrl    = AC_TAD;
            LK_ctrl    = LK_TAD;
            PC_ctrl    = PC_P1;
            instr_done = 1'b1;
            w_next     = F_AD;
          end
          OP_ISZ: begin
            MB_ctrl = MB_INC;
            w_next  = WR_WD;
          end
          default: begin
            w_next = F_AD;
          end
        endcase
      end

      WR_WD: begin
        WD_ctrl = WD_MB;
        w_next  = WR;
      end

      WR: begin
        mem_wr = 1'b1;
        if (mem_done) begin
          if (r_auto) begin
            w_next = E_AD;
          end else begin
            case (w_opcode)
              OP_DCA: begin
                AC_ctrl    = AC_CLEAR;
                PC_ctrl    = PC_P1;
                instr_done = 1'b1;
                w_next     = F_AD;
              end
              OP_ISZ: begin
                // MB already holds the incremented value at this point.
                PC_ctrl    = mb_is_zero ? PC_P2 : PC_P1;
                instr_done = 1'b1;
                w_next     = F_AD;
              end
              OP_JMS: begin
                PC_ctrl = PC_JMP;
                w_next  = JMS_P1;
              end
              default: begin
                PC_ctrl    = PC_P1;
                instr_done = 1'b1;
                w_next     = F_AD;
              end
            endcase
          end
        end
      end

      JMS_P1: begin
        PC_ctrl    = PC_P1;
        instr_done = 1'b1;
        w_next     = F_AD;
      end

      HALT: begin
        if (run) w_next = F_AD;
      end

      default: begin
        w_next = IDLE;
      end
    endcase

    // A reset cycle must not let a same-cycle mem_done or run leak into the datapath.
    if (reset) begin
      AC_ctrl    = AC_NC;
      LK_ctrl    = LK_NC;
      PC_ctrl    = PC_NC;
      IR_ctrl    = IR_NC;
      EA_ctrl    = EA_NC;
      MB_ctrl    = MB_NC;
      WD_ctrl    = WD_NC;
      AD_ctrl    = AD_NC;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_ac_sequencer.sv
module tb_ac_sequencer;
  import ac_sequencer_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, run, halt_req;
  logic [11:0] ir;
  logic        ea_in_auto, mb_is_zero, skip, mem_done;
  ac_ctrl_e AC_ctrl; lk_ctrl_e LK_ctrl; pc_ctrl_e PC_ctrl; ir_ctrl_e IR_ctrl;
  ea_ctrl_e EA_ctrl; mb_ctrl_e MB_ctrl; wd_ctrl_e WD_ctrl; ad_ctrl_e AD_ctrl;
  logic mem_rd, mem_wr, halted, instr_done;

  ac_sequencer #(.HLT_CODE(12'o7402)) dut (
    .clock(clock), .reset(reset), .run(run), .halt_req(halt_req), .ir(ir),
    .ea_in_auto(ea_in_auto), .mb_is_zero(mb_is_zero), .skip(skip), .mem_done(mem_done),
    .AC_ctrl(AC_ctrl), .LK_ctrl(LK_ctrl), .PC_ctrl(PC_ctrl), .IR_ctrl(IR_ctrl),
    .EA_ctrl(EA_ctrl), .MB_ctrl(MB_ctrl), .WD_ctrl(WD_ctrl), .AD_ctrl(AD_ctrl),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .instr_done(instr_done)
  );

  // Behavioural datapath and memory, steered by the sequencer's controls.
  logic [11:0] mem [0:4095];
  logic [11:0] m_ac, m_pc, m_ir, m_ea, m_mb, m_ad, m_wd;
  logic        m_l;
  logic [1:0]  m_cnt;
  logic        tb_init, ld_en, stall, force_done;
  logic [11:0] ld_addr, ld_dat;
  logic [11:0] rd_dat, micro_ac;
  logic        micro_l;
  logic [12:0] tad_sum;

  assign rd_dat     = mem[m_ad];
  assign ir         = m_ir;
  assign ea_in_auto = (m_ea[11:3] == 9'o001);
  assign mb_is_zero = (m_mb == 12'd0);
  assign skip       = m_ir[8] & ((m_ir[6] & m_ac[11]) | (m_ir[5] & (m_ac == 12'd0)));
  assign tad_sum    = {1'b0, m_ac} + {1'b0, m_mb};
  assign mem_done   = force_done |
                      ((mem_rd | mem_wr) && (m_cnt == 2'd1) && !(stall && (m_ad == 12'o0340)));

  always_comb begin
    micro_ac = m_ac;
    micro_l  = m_l;
    if (m_ir[7]) micro_ac = 12'd0;
    if (!m_ir[8]) begin
      if (m_ir[6]) micro_l = 1'b0;
      if (m_ir[0]) micro_ac = micro_ac + 12'd1;
    end
  end

  always @(posedge clock) begin
    if (tb_init) begin
      m_pc <= 12'o0200; m_ac <= 12'o7776; m_l <= 1'b0;
      m_ir <= 12'd0; m_ea <= 12'd0; m_mb <= 12'd0; m_ad <= 12'd0; m_wd <= 12'd0;
    end else begin
      case (AD_ctrl) AD_PC: m_ad <= m_pc; AD_EA: m_ad <= m_ea; default: ; endcase
      if (IR_ctrl == IR_LD) m_ir <= rd_dat;
      case (MB_ctrl) MB_RD: m_mb <= rd_dat; MB_INC: m_mb <= m_mb + 12'd1; default: ; endcase
      case (EA_ctrl)
        EA_PGE: m_ea <= {m_pc[11:7], m_ir[6:0]};
        EA_SMP: m_ea <= {5'd0, m_ir[6:0]};
        EA_IND: m_ea <= m_mb;
        EA_INC: m_ea <= m_mb + 12'd1;
        default: ;
      endcase
      case (WD_ctrl)
        WD_MB: m_wd <= m_mb; WD_AC: m_wd <= m_ac; WD_PCP1: m_wd <= m_pc + 12'd1; default: ;
      endcase
      case (PC_ctrl)
        PC_P1: m_pc <= m_pc + 12'd1; PC_P2: m_pc <= m_pc + 12'd2; PC_JMP: m_pc <= m_ea; default: ;
      endcase
      case (AC_ctrl)
        AC_MICRO: m_ac <= micro_ac; AC_AND: m_ac <= m_ac & m_mb;
        AC_TAD: m_ac <= tad_sum[11:0]; AC_CLEAR: m_ac <= 12'd0; default: ;
      endcase
      case (LK_ctrl) LK_MICRO: m_l <= micro_l; LK_TAD: m_l <= m_l ^ tad_sum[12]; default: ; endcase
    end
    if (ld_en) mem[ld_addr] <= ld_dat;
    else if (mem_wr && mem_done) mem[m_ad] <= m_wd;
    if ((mem_rd | mem_wr) && !mem_done) m_cnt <= (m_cnt == 2'd3) ? m_cnt : m_cnt + 2'd1;
    else m_cnt <= 2'd0;
  end

  // Scoreboard of architectural state expected after each retire.
  typedef struct {
    int          id;
    logic [11:0] ac;
    logic        l;
    logic [11:0] pc;
    logic        chk_mem;
    logic [11:0] addr;
    logic [11:0] dat;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %o want %o", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [11:0] ac, input logic l, input logic [11:0] pc,
                      input logic cm, input logic [11:0] a, input logic [11:0] d);
    exp_t e;
    e.id = id; e.ac = ac; e.l = l; e.pc = pc; e.chk_mem = cm; e.addr = a; e.dat = d;
    sb.push_back(e);
  endtask

  // Monitor: a retire seen on one falling edge is checked on the next, after the datapath update.
  initial begin : monitor
    bit   pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (pend) begin
        pend = 1'b0;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_retire: got pc %o want no retire", m_pc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("retire%0d_ac", e.id), m_ac, e.ac);
          chk($sformatf("retire%0d_link", e.id), {11'd0, m_l}, {11'd0, e.l});
          chk($sformatf("retire%0d_pc", e.id), m_pc, e.pc);
          if (e.chk_mem) chk($sformatf("retire%0d_mem%o", e.id, e.addr), mem[e.addr], e.dat);
        end
      end
      if (instr_done) pend = 1'b1;
    end
  end

  task automatic ld(input logic [11:0] a, input logic [11:0] d);
    ld_en = 1'b1; ld_addr = a; ld_dat = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic wait_halted(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (halted) break;
    end
    chk(nm, {11'd0, halted}, 12'd1);
  endtask

  initial begin : stim
    reset = 1'b1; run = 1'b1; halt_req = 1'b0; force_done = 1'b0; stall = 1'b0;
    ld_en = 1'b0; ld_addr = 12'd0; ld_dat = 12'd0; tb_init = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0; run = 1'b0;
    #1;
    // run held high throughout reset must not have moved the sequencer out of IDLE
    chk("rst_ad_ctrl", 12'(AD_ctrl), 12'(AD_NC));
    chk("rst_mem_rd", {11'd0, mem_rd}, 12'd0);
    chk("rst_mem_wr", {11'd0, mem_wr}, 12'd0);
    chk("rst_halted", {11'd0, halted}, 12'd0);
    chk("rst_instr_done", {11'd0, instr_done}, 12'd0);
    chk("rst_pc_ctrl", 12'(PC_ctrl), 12'(PC_NC));
    chk("rst_ir_ctrl", 12'(IR_ctrl), 12'(IR_NC));
    chk("rst_ac_ctrl", 12'(AC_ctrl), 12'(AC_NC));

    ld(12'o0200, 12'o1250); ld(12'o0201, 12'o2050); ld(12'o0202, 12'o7200);
    ld(12'o0203, 12'o1410); ld(12'o0204, 12'o3251); ld(12'o0205, 12'o5300);
    ld(12'o0250, 12'o0003); ld(12'o0251, 12'o0000); ld(12'o0050, 12'o7777);
    ld(12'o0010, 12'o0377); ld(12'o0377, 12'o0100); ld(12'o0400, 12'o0005);
    ld(12'o0300, 12'o4320); ld(12'o0320, 12'o0000); ld(12'o0321, 12'o1340);
    ld(12'o0322, 12'o0341); ld(12'o0323, 12'o7440); ld(12'o0324, 12'o7200);
    ld(12'o0325, 12'o7440); ld(12'o0326, 12'o7200); ld(12'o0327, 12'o6000);
    ld(12'o0330, 12'o7402); ld(12'o0331, 12'o7001); ld(12'o0332, 12'o7402);
    ld(12'o0333, 12'o1340); ld(12'o0340, 12'o0017); ld(12'o0341, 12'o0005);
    tb_init = 1'b0;

    push(1,  12'o0001, 1'b1, 12'o0201, 1'b0, 12'o0000, 12'o0000); // TAD carry into link
    push(2,  12'o0001, 1'b1, 12'o0203, 1'b1, 12'o0050, 12'o0000); // ISZ wraps and skips
    push(3,  12'o0006, 1'b1, 12'o0204, 1'b1, 12'o0010, 12'o0400); // auto-index TAD I
    push(4,  12'o0000, 1'b1, 12'o0205, 1'b1, 12'o0251, 12'o0006); // DCA
    push(5,  12'o0000, 1'b1, 12'o0300, 1'b0, 12'o0000, 12'o0000); // JMP
    push(6,  12'o0000, 1'b1, 12'o0321, 1'b1, 12'o0320, 12'o0301); // JMS
    push(7,  12'o0017, 1'b1, 12'o0322, 1'b0, 12'o0000, 12'o0000); // TAD page
    push(8,  12'o0005, 1'b1, 12'o0323, 1'b0, 12'o0000, 12'o0000); // AND
    push(9,  12'o0005, 1'b1, 12'o0324, 1'b0, 12'o0000, 12'o0000); // SZA, no skip
    push(10, 12'o0000, 1'b1, 12'o0325, 1'b0, 12'o0000, 12'o0000); // CLA
    push(11, 12'o0000, 1'b1, 12'o0327, 1'b0, 12'o0000, 12'o0000); // SZA, skip
    push(12, 12'o0000, 1'b1, 12'o0330, 1'b0, 12'o0000, 12'o0000); // IOT
    run = 1'b1; @(negedge clock); run = 1'b0;
    wait_halted("hlt1_halted", 2000);
    chk("hlt1_pc", m_pc, 12'o0331);
    chk("hlt1_queue_empty", 12'(sb.size()), 12'd0);

    // resume from HALT fetches the word after the HLT
    push(13, 12'o0001, 1'b1, 12'o0332, 1'b0, 12'o0000, 12'o0000); // IAC
    run = 1'b1; @(negedge clock); run = 1'b0;
    chk("resume_left_halt", {11'd0, halted}, 12'd0);
    wait_halted("hlt2_halted", 500);
    chk("hlt2_pc", m_pc, 12'o0333);

    // front-panel stop: sampled in the fetch-address state, no memory read follows
    halt_req = 1'b1; run = 1'b1;
    @(negedge clock); run = 1'b0;
    #1;
    chk("hreq_fad_ad_ctrl", 12'(AD_ctrl), 12'(AD_PC));
    @(negedge clock); halt_req = 1'b0;
    #1;
    chk("hreq_halted", {11'd0, halted}, 12'd1);
    chk("hreq_no_read", {11'd0, mem_rd}, 12'd0);
    chk("hreq_pc", m_pc, 12'o0333);

    // reset during a stalled operand read
    stall = 1'b1; run = 1'b1;
    @(negedge clock); run = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rd && (m_ad == 12'o0340)) break;
      @(negedge clock);
    end
    chk("erd_reached", {11'd0, mem_rd}, 12'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_erd_mem_rd", {11'd0, mem_rd}, 12'd0);
    chk("rst_erd_mem_wr", {11'd0, mem_wr}, 12'd0);
    reset = 1'b0; stall = 1'b0; force_done = 1'b1;
    #1;
    chk("late_done_ad_ctrl", 12'(AD_ctrl), 12'(AD_NC));
    chk("late_done_mb_ctrl", 12'(MB_ctrl), 12'(MB_NC));
    chk("late_done_halted", {11'd0, halted}, 12'd0);
    @(negedge clock); force_done = 1'b0;
    #1;
    chk("post_late_mem_rd", {11'd0, mem_rd}, 12'd0);
    chk("post_late_ir_ctrl", 12'(IR_ctrl), 12'(IR_NC));
    chk("post_late_ac", m_ac, 12'o0001);
    repeat (4) @(negedge clock);
    chk("final_queue_empty", 12'(sb.size()), 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
